// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: captures a decimated record of DEPTH ADC samples after
// an arm pulse. It then serves the record as a HI/LO byte stream, one byte per
// host read request.
// Latency: the first write is DECIM cycles after arm. rd_byte is valid 2 cycles
// after entering READY and 2 cycles after each accepted rd_req.
// Backpressure: the host paces readout with rd_req and must wait for rd_valid.
// A rd_req made while rd_valid is low is dropped.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   adc              raw ADC code, asynchronous to clk; it is registered first
//   arm              one-cycle pulse that starts a capture (from IDLE or READY)
//   rd_req           one-cycle pulse: the host consumed rd_byte
//   rd_byte/rd_valid current readout byte and its qualifier
//   busy/done/count  capture status: done pulses on the final write
module adc_capture_buffer #(
  parameter int DEPTH = 256,
  parameter int DECIM = 48,
  parameter int ADC_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADC_W-1:0]         adc,
  input  logic                     arm,
  input  logic                     rd_req,
  output logic [7:0]               rd_byte,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_READY   = 2'd2;

  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [DW-1:0] DIV_ONE  = 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DECIM - 1);

  logic [1:0]       state_q, state_d;
  logic [ADC_W-1:0] adc_q;
  logic [DW-1:0]    div_q, div_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic             phase_q, phase_d;      // 0: HI byte, 1: LO byte
  logic             fin_q, fin_d;          // whole record consumed
  logic [1:0]       lat_q, lat_d;          // cycles left until rd_byte is refreshed
  logic [7:0]       rd_byte_q, rd_byte_d;
  logic             rd_valid_q, rd_valid_d;
  logic [ADC_W-1:0] rdata_q;
  logic [15:0]      samp16;

  logic             we;
  logic             last_wr;
  logic             rd_acc;

  logic [ADC_W-1:0] mem [DEPTH];

  assign we      = (state_q == S_CAPTURE) && (div_q == DIV_LAST);
  assign last_wr = we && (wptr_q == PTR_LAST);
  // arm takes priority over a read request in the same cycle
  assign rd_acc  = (state_q == S_READY) && rd_valid_q && !fin_q && rd_req && !arm;
  // zero-extend so the HI byte carries the sample bits above bit 7
  assign samp16  = 16'(rdata_q);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    rptr_d     = rptr_q;
    phase_d    = phase_q;
    fin_d      = fin_q;
    lat_d      = lat_q;
    rd_byte_d  = rd_byte_q;
    rd_valid_d = rd_valid_q;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_CAPTURE;
          div_d   = '0;
          wptr_d  = '0;
          count_d = '0;
        end
      end

      S_CAPTURE: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
        if (we) begin
          wptr_d  = wptr_q + PTR_ONE;
          count_d = count_q + CNT_ONE;
        end
        if (last_wr) begin
          state_d    = S_READY;
          rptr_d     = '0;
          phase_d    = 1'b0;
          fin_d      = 1'b0;
          lat_d      = 2'd2;
          rd_valid_d = 1'b0;
          rd_byte_d  = 8'hFF;
        end
      end

      S_READY: begin
        if (arm) begin
          state_d    = S_CAPTURE;
          div_d      = '0;
          wptr_d     = '0;
          count_d    = '0;
          lat_d      = 2'd0;
          rd_valid_d = 1'b0;
          rd_byte_d  = 8'hFF;
        end else if (lat_q != 2'd0) begin
          // rdata_q already holds mem[rptr_q] when lat_q reaches 1
          lat_d = lat_q - 2'd1;
          if (lat_q == 2'd1) begin
            rd_valid_d = 1'b1;
            rd_byte_d  = fin_q ? 8'hFF : (phase_q ? samp16[7:0] : samp16[15:8]);
          end
        end else if (rd_acc) begin
          if (phase_q) begin
            phase_d = 1'b0;
            if (rptr_q == PTR_LAST) fin_d  = 1'b1;
            else                    rptr_d = rptr_q + PTR_ONE;
          end else begin
            phase_d = 1'b1;
          end
          lat_d      = 2'd2;
          rd_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    adc_q <= adc;
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      rptr_q     <= '0;
      phase_q    <= 1'b0;
      fin_q      <= 1'b0;
      lat_q      <= 2'd0;
      rd_byte_q  <= 8'hFF;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      phase_q    <= phase_d;
      fin_q      <= fin_d;
      lat_q      <= lat_d;
      rd_byte_q  <= rd_byte_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Sample RAM without reset so it maps onto block RAM, with a registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[wptr_q] <= adc_q;
    rdata_q <= mem[rptr_q];
  end

  assign rd_byte  = rd_byte_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == S_CAPTURE);
  assign done     = last_wr && !rst;
  assign count    = count_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
module tb_adc_capture_buffer;
  localparam int DEPTH = 8;
  localparam int DECIM = 4;
  localparam int ADC_W = 10;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int HMAX  = 8192;

  logic             clk = 1'b0;
  logic             rst;
  logic [ADC_W-1:0] adc;
  logic             arm;
  logic             rd_req;
  logic [7:0]       rd_byte;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic [CW-1:0]    count;

  adc_capture_buffer #(.DEPTH(DEPTH), .DECIM(DECIM), .ADC_W(ADC_W)) dut (
    .clk(clk), .rst(rst), .adc(adc), .arm(arm), .rd_req(rd_req),
    .rd_byte(rd_byte), .rd_valid(rd_valid), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;     // number of the last rising edge
  int t_arm  = 0;     // edge at which the current capture's arm was sampled
  logic [ADC_W-1:0] hist [HMAX];   // adc value sampled at each edge
  logic [ADC_W-1:0] rec  [DEPTH];  // expected stored record

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    if (cyc + 1 < HMAX) hist[cyc + 1] = adc;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // mode 0: random, mode 1: constant 3A5, mode 2: decimation slot index
  task automatic drive_adc(input int mode);
    case (mode)
      1:       adc = 10'h3A5;
      2:       adc = ADC_W'((cyc + 1 - t_arm) / DECIM);
      default: adc = ADC_W'($urandom);
    endcase
  endtask

  // Sample k of a capture armed at edge t is the adc value sampled one edge
  // before its write at edge t + DECIM*(k+1).
  function automatic logic [7:0] exp_byte(input int b);
    logic [15:0] v;
    if (b >= 2 * DEPTH) return 8'hFF;
    v = 16'(rec[b / 2]);
    return (b % 2 == 0) ? v[15:8] : v[7:0];
  endfunction

  task automatic capture(input int mode, input bit with_req, input bit rearm,
                         input int rst_at_sample);
    int el;
    arm = 1'b1;
    rd_req = with_req;
    t_arm = cyc + 1;
    drive_adc(mode);
    step();
    arm = 1'b0;
    rd_req = 1'b0;
    chk("busy_after_arm", busy, 1);
    chk("rd_valid_after_arm", rd_valid, 0);
    while (cyc < t_arm + DECIM * DEPTH) begin
      el = cyc - t_arm;
      chk("cap_count", count, el / DECIM);
      chk("cap_busy", busy, 1);
      chk("cap_done", done, int'(cyc + 1 == t_arm + DECIM * DEPTH));
      chk("cap_rd_valid", rd_valid, 0);
      if (rst_at_sample >= 0 && el == DECIM * rst_at_sample + 1) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_byte", rd_byte, 8'hFF);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_done", done, 0);
        return;
      end
      arm = rearm && (el == DECIM * 3 + 1);
      rd_req = 1'($urandom_range(0, 1));
      drive_adc(mode);
      step();
      arm = 1'b0;
      rd_req = 1'b0;
    end
    for (int k = 0; k < DEPTH; k++) rec[k] = hist[t_arm + DECIM * (k + 1) - 1];
    chk("end_count", count, DEPTH);
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
  endtask

  task automatic wait_valid();
    int lat = 0;
    while (!rd_valid && lat < 10) begin
      rd_req = 1'($urandom_range(0, 1));   // ignored while rd_valid is low
      adc = ADC_W'($urandom);
      step();
      lat++;
    end
    rd_req = 1'b0;
    chk("rd_latency", lat, 2);
  endtask

  task automatic read_bytes(input int from, input int n);
    for (int b = from; b < from + n; b++) begin
      wait_valid();
      chk("rd_byte", rd_byte, exp_byte(b));
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      chk("rd_valid_drop", rd_valid, 0);
    end
  endtask

  task automatic check_exhausted();
    wait_valid();
    chk("end_byte", rd_byte, 8'hFF);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("end_hold_valid", rd_valid, 1);
      chk("end_hold_byte", rd_byte, 8'hFF);
      step();
    end
    chk("count_hold", count, DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arm = 1'b0; rd_req = 1'b0; adc = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_byte", rd_byte, 8'hFF);
    chk("reset_count", count, 0);
    chk("reset_done", done, 0);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("idle_rd_valid", rd_valid, 0);
    chk("idle_rd_byte", rd_byte, 8'hFF);
    for (int i = 0; i < 6; i++) step();

    // slot-index record with a re-arm at sample 3 that must be ignored
    capture(2, 1'b0, 1'b1, -1);
    read_bytes(0, 2 * DEPTH);
    check_exhausted();

    // constant code: HI/LO split of sample 0
    capture(1, 1'b0, 1'b0, -1);
    wait_valid();
    chk("hi_3a5", rd_byte, 8'h03);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    wait_valid();
    chk("lo_3a5", rd_byte, 8'hA5);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    read_bytes(2, 3);
    wait_valid();

    // arm together with rd_req after 5 bytes: arm wins
    capture(0, 1'b1, 1'b0, -1);
    read_bytes(0, 2 * DEPTH);
    check_exhausted();

    // reset in the middle of a capture
    capture(0, 1'b0, 1'b0, 5);
    for (int i = 0; i < DECIM * DEPTH; i++) begin
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
      step();
    end

    // fresh random capture after reset
    capture(0, 1'b0, 1'b0, -1);
    read_bytes(0, 2 * DEPTH);
    check_exhausted();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_capture_buffer.md
Name: adc_capture_buffer

Overview:
- Sits between the 10-bit echo ADC and the I2C peripheral. Its byte output drives the I2C peripheral `tx` byte.
- On an `arm` pulse it decimates the free-running ADC stream and stores DEPTH samples in block RAM.
- After capture it serves the stored samples to the I2C host as a byte stream, one byte per read request.
- It gives the host a whole echo record per ping, so the host never has to stream live ADC codes.

Parameters:
- DEPTH, 256, number of samples per capture; must be a power of 2, at least 4.
- DECIM, 48, clk cycles per stored sample; at least 2 (48 MHz clock gives 1 MS/s).
- ADC_W, 10, ADC sample width; at most 16.

Ports:
- clk  input  1  system clock (HSOSC 48 MHz).
- rst  input  1  reset; the only clock is clk, and reset is synchronous to it and active-high.
- adc  input  ADC_W  raw ADC code; asynchronous to clk, sampled only through an internal register.
- arm  input  1  single-cycle pulse that starts a capture.
- rd_req  input  1  single-cycle pulse: the host consumed the current byte, advance to the next.
- rd_byte  output  8  current readout byte.
- rd_valid  output  1  rd_byte is stable and belongs to the current record.
- busy  output  1  capture in progress.
- done  output  1  single-cycle pulse when the last sample is written.
- count  output  $clog2(DEPTH)+1  samples written in the current or last capture.

Behaviour:
- Reset values: state IDLE, rd_byte 8'hFF, rd_valid 0, busy 0, done 0, count 0, all pointers and divider 0. RAM contents are undefined.
- Input register: adc_q <= adc every cycle. Only adc_q is ever written to RAM.
- States: IDLE, CAPTURE, READY.
- IDLE:
  - busy 0, rd_valid 0, rd_byte 8'hFF.
  - arm -> CAPTURE on the next cycle, with count 0, div 0, wptr 0.
  - rd_req is ignored.
- CAPTURE:
  - busy 1. div counts 0..DECIM-1, then wraps.
  - On each cycle with div==DECIM-1: write RAM[wptr] <= adc_q, then wptr++ and count++.
  - If arm pulses at cycle t, the first write is at cycle t+DECIM.
  - When the write of sample DEPTH-1 occurs: done=1 for that single cycle, then next state is READY with rptr 0 and byte phase HI.
  - arm during CAPTURE is ignored (no restart).
  - rd_req during CAPTURE is ignored; rd_valid stays 0.
- READY:
  - Byte order per sample: HI byte = {(16-ADC_W) zeros, sample[ADC_W-1:8]}, then LO byte = sample[7:0]. Samples go out in index order 0..DEPTH-1.
  - Read latency: the RAM read is registered. rd_byte updates 2 cycles after READY entry or after an accepted rd_req. rd_valid is 0 during those 2 cycles and 1 otherwise.
  - rd_req while rd_valid=0 is ignored; the host must wait for rd_valid.
  - rd_req on an LO byte advances rptr and returns phase to HI. rd_req on a HI byte sets phase to LO with the same rptr.
  - Boundary, after the LO byte of sample DEPTH-1 is consumed: rptr saturates. rd_byte = 8'hFF and rd_valid = 1 permanently, and further rd_req have no effect.
  - arm in READY -> CAPTURE, discarding the old record. rd_valid drops to 0 on the next cycle.
- Simultaneous arm and rd_req in READY: arm wins and rd_req is dropped.
- Reset mid-capture or mid-readout: return to the reset values on the next edge. No done pulse is produced.
- count saturates at DEPTH and holds until the next arm.

Test Plan:
- Reset during CAPTURE at sample 37 -> next cycle busy=0, count=0, rd_byte=8'hFF, no done pulse.
- With DEPTH=8, DECIM=4 and adc driven to the sample index (adc=n for the n-th decimation slot): arm at cycle 10 -> writes at cycles 14, 18, …, 42. done pulses at cycle 42, count=8.
- Readout of that record: issue 16 rd_req, each waiting for rd_valid -> bytes 00,00,00,01,00,02,…,00,07. A 17th rd_req -> rd_byte 8'hFF.
- adc=10'h3A5 constant, capture, then read sample 0 -> HI byte 8'h03, LO byte 8'hA5.
- arm pulsed again mid-capture at sample 3 -> ignored: done still at the original cycle, count=8.
- In READY after 5 bytes read, assert arm and rd_req in the same cycle -> new capture starts, rd_valid=0 next cycle, busy=1.
